// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data memory access controller (byte/half/word, RMW sub-word stores)
module dmem_access_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_wen,
    output logic              mem_readEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_dataIn,
    input  logic [31:0]       mem_dataOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;

    // Upper address bits are intentionally dropped: addresses wrap modulo depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
        is_bad_req = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0:    extract_load = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    extract_load = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: extract_load = word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the old word; the rest is written back unchanged.
    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] lane;
        case (size)
            2'd0: begin
                mask = 32'h0000_00FF;
                lane = {24'd0, wdata[7:0]};
            end
            2'd1: begin
                mask = 32'h0000_FFFF;
                lane = {16'd0, wdata[15:0]};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                lane = wdata;
            end
        endcase
        mask = mask << {off, 3'b000};
        lane = lane << {off, 3'b000};
        merge_store = (old & ~mask) | lane;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'd0;
            lat_wdata    <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            mem_wen      <= 1'b0;
            mem_readEn   <= 1'b0;
            mem_address  <= '0;
            mem_dataIn   <= 32'd0;
        end else begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'd0;
            mem_wen    <= 1'b0;
            mem_readEn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata;
                        if (is_bad_req(req_size, req_addr[1:0])) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (!req_write || req_size != 2'd2) begin
                            state       <= S_READ;
                            mem_readEn  <= 1'b1;
                            mem_address <= req_addr[ADDR_W+1:2];
                        end else begin
                            state       <= S_WRITE;
                            mem_wen     <= 1'b1;
                            mem_address <= req_addr[ADDR_W+1:2];
                            mem_dataIn  <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (lat_write) begin
                        state      <= S_WRITE;
                        mem_wen    <= 1'b1;
                        mem_dataIn <= merge_store(mem_dataOut, lat_wdata, lat_size, lat_off);
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extract_load(mem_dataOut, lat_size, lat_off, lat_unsigned);
                    end
                end
                S_WRITE: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl with byte-level reference model
module tb_dmem_access_ctrl;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err, busy, mem_wen, mem_readEn;
    logic [31:0]       rsp_rdata, mem_dataIn, mem_dataOut;
    logic [ADDR_W-1:0] mem_address;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .mem_wen(mem_wen), .mem_readEn(mem_readEn),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    logic [31:0] mem [0:31];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign mem_dataOut = mem[mem_address];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wen) mem[mem_address] <= mem_dataIn;
    end

    logic [7:0] ref_bytes [0:127];
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic ref_is_err(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'd3) || ((ad % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input logic [31:0] ad);
        logic [31:0] v = 0;
        logic [31:0] sb;
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[7'(ad[6:0] + 7'(i))]) << (8 * i));
        if (!un && nb < 4) begin
            sb = 32'd1 << (8 * nb - 1);
            v = (v ^ sb) - sb;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) ref_bytes[7'(ad[6:0] + 7'(i))] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    function automatic int image_diffs();
        int d = 0;
        for (int w = 0; w < 32; w++) if (mem[w] !== ref_word(w)) d++;
        return d;
    endfunction

    task automatic preload(input int w, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 5'(w); pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_store(2'd2, 32'(w * 4), v);
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int wen_n, output int ren_n, output int wen_cyc,
                           output int ren_cyc, output logic [4:0] wen_addr);
        lat = -1; rd = 0; er = 0; wen_n = 0; ren_n = 0; wen_cyc = -1; ren_cyc = -1; wen_addr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_write = 1'($urandom);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            if (mem_wen) begin wen_n++; wen_cyc = c; wen_addr = mem_address; end
            if (mem_readEn) begin ren_n++; ren_cyc = c; end
            if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; end
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({req_ready, busy, mem_wen, mem_readEn, rsp_valid, rsp_err} !== 6'b100000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 100000", {req_ready, busy, mem_wen, mem_readEn, rsp_valid, rsp_err}); end
        n_vec++; if ({rsp_rdata, mem_dataIn, mem_address} !== '0) begin
            n_bad++; $display("FAIL reset_data: rdata=%h dataIn=%h addr=%0d expected all 0", rsp_rdata, mem_dataIn, mem_address); end
    endtask

    task automatic test_word_store_load();
        int lat, wn, rn, wc, rc; logic [31:0] rd; logic er; logic [4:0] wa;
        run_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, lat, rd, er, wn, rn, wc, rc, wa);
        ref_store(2'd2, 32'h08, 32'hDEADBEEF);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        n_vec++; if (wn !== 1 || wa !== 5'd2 || rn !== 0) begin
            n_bad++; $display("FAIL sw_pins: wen=%0d addr=%0d ren=%0d expected 1/2/0", wn, wa, rn); end
        run_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, lat, rd, er, wn, rn, wc, rc, wa);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_merge();
        int lat, wn, rn, wc, rc; logic [31:0] rd; logic er; logic [4:0] wa;
        preload(3, 32'h11223344);
        run_req(1'b1, 2'd0, 1'b0, 32'h0E, 32'hFFFFFFAA, lat, rd, er, wn, rn, wc, rc, wa);
        ref_store(2'd0, 32'h0E, 32'hFFFFFFAA);
        n_vec++; if (rc !== 1 || wc !== 2) begin n_bad++; $display("FAIL sb_sequence: read cyc %0d write cyc %0d expected 1/2", rc, wc); end
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        n_vec++; if (mem[3] !== 32'h11AA3344) begin n_bad++; $display("FAIL sb_merge: got %h expected 11aa3344", mem[3]); end
        n_vec++; if (rd !== 32'd0 || er !== 1'b0) begin n_bad++; $display("FAIL sb_rsp: rdata %h err %b expected 0/0", rd, er); end
    endtask

    task automatic test_extension();
        logic [1:0]  sz[4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        un[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad[4]  = '{32'h07, 32'h07, 32'h04, 32'h06};
        logic [31:0] exp[4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080F0};
        int lat, wn, rn, wc, rc; logic [31:0] rd; logic er; logic [4:0] wa;
        preload(1, 32'h80F07F01);
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, wn, rn, wc, rc, wa);
            n_vec++; if (rd !== exp[i] || lat !== 2) begin
                n_bad++; $display("FAIL ext_load[%0d]: got %h lat %0d expected %h lat 2", i, rd, lat, exp[i]); end
        end
    endtask

    task automatic test_misaligned();
        logic        wr[3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz[3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ad[3] = '{32'h05, 32'h03, 32'h00};
        int lat, wn, rn, wc, rc; logic [31:0] rd; logic er; logic [4:0] wa;
        for (int i = 0; i < 3; i++) begin
            run_req(wr[i], sz[i], 1'b0, ad[i], 32'h12345678, lat, rd, er, wn, rn, wc, rc, wa);
            n_vec++; if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
                n_bad++; $display("FAIL misaligned_rsp[%0d]: lat %0d err %b rdata %h expected 1/1/0", i, lat, er, rd); end
            n_vec++; if (wn !== 0 || rn !== 0) begin
                n_bad++; $display("FAIL misaligned_enables[%0d]: wen %0d ren %0d expected 0/0", i, wn, rn); end
        end
        n_vec++; if (image_diffs() !== 0) begin n_bad++; $display("FAIL misaligned_image: %0d words differ, expected 0", image_diffs()); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0; logic [31:0] rd = 32'hX;
        preload(0, 32'hCAFE0000);
        preload(1, 32'h01010101);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h00;
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h04; req_wdata = 32'h0BADF00D;
        for (int c = 1; c <= 2; c++) begin
            if (busy && !req_ready) busy_cnt++;
            if (rsp_valid) rd = rsp_rdata;
            if (c == 2) req_wdata = 32'h600DD00D;
            @(negedge clk);
        end
        n_vec++; if (busy_cnt !== 2 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_stall: busy cycles %0d, idle busy=%b ready=%b expected 2/0/1", busy_cnt, busy, req_ready); end
        n_vec++; if (rd !== 32'hCAFE0000) begin n_bad++; $display("FAIL b2b_load: got %h expected cafe0000", rd); end
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (mem_wen !== 1'b1 || mem_address !== 5'd1 || mem_dataIn !== 32'h600DD00D) begin
            n_bad++; $display("FAIL b2b_store: wen %b addr %0d data %h expected 1/1/600dd00d", mem_wen, mem_address, mem_dataIn); end
        @(negedge clk);
        ref_store(2'd2, 32'h04, 32'h600DD00D);
        n_vec++; if (rsp_valid !== 1'b1 || image_diffs() !== 0) begin
            n_bad++; $display("FAIL b2b_done: rsp_valid %b, %0d words differ, expected 1/0", rsp_valid, image_diffs()); end
    endtask

    task automatic test_reset_mid_store();
        int rsp_cnt = 0;
        preload(4, 32'h44444444);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h99999999;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (mem_wen !== 1'b1) begin n_bad++; $display("FAIL rst_store_write_phase: wen %b expected 1", mem_wen); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen_drop: wen %b expected 0", mem_wen); end
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++; if (mem[4] !== 32'h44444444) begin n_bad++; $display("FAIL rst_mem_kept: got %h expected 44444444", mem[4]); end
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) rsp_cnt++;
            @(negedge clk);
        end
        n_vec++; if (rsp_cnt !== 0) begin n_bad++; $display("FAIL rst_no_rsp: %0d pulses expected 0", rsp_cnt); end
        n_vec++; if ({req_ready, busy, mem_wen, mem_readEn, rsp_valid, rsp_err} !== 6'b100000 || rsp_rdata !== 32'd0) begin
            n_bad++; $display("FAIL rst_idle: flags %b rdata %h expected 100000/0", {req_ready, busy, mem_wen, mem_readEn, rsp_valid, rsp_err}, rsp_rdata); end
    endtask

    task automatic test_random();
        int lat, wn, rn, wc, rc, exp_lat; logic [31:0] rd, exp_rd, ad, wd; logic er, exp_err, wr, un;
        logic [1:0] sz; logic [4:0] wa;
        for (int k = 0; k < 300; k++) begin
            sz = 2'($urandom_range(0, 3)); wr = 1'($urandom); un = 1'($urandom);
            ad = $urandom; wd = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 1);
            exp_err = ref_is_err(sz, ad);
            exp_lat = exp_err ? 1 : (wr && sz != 2'd2) ? 3 : 2;
            exp_rd  = (!exp_err && !wr) ? ref_load(sz, un, ad) : 32'd0;
            run_req(wr, sz, un, ad, wd, lat, rd, er, wn, rn, wc, rc, wa);
            if (!exp_err && wr) ref_store(sz, ad, wd);
            n_vec++; if (lat !== exp_lat || er !== exp_err || rd !== exp_rd) begin
                n_bad++; $display("FAIL rand_rsp[%0d] wr=%b sz=%0d ad=%h: lat %0d err %b rdata %h expected %0d %b %h",
                                  k, wr, sz, ad, lat, er, rd, exp_lat, exp_err, exp_rd); end
            n_vec++; if (wn !== ((!exp_err && wr) ? 1 : 0) || rn !== ((!exp_err && (!wr || sz != 2'd2)) ? 1 : 0)) begin
                n_bad++; $display("FAIL rand_enables[%0d]: wen %0d ren %0d", k, wn, rn); end
            n_vec++; if (image_diffs() !== 0) begin
                n_bad++; $display("FAIL rand_image[%0d]: %0d words differ, expected 0", k, image_diffs()); end
        end
    endtask

    initial begin
        test_reset();
        for (int w = 0; w < 32; w++) preload(w, $urandom);
        test_word_store_load();
        test_byte_merge();
        test_extension();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the single-port data memory in the MEM stage of the pipelined MIPS core.
- Accepts one load/store request at a time from the pipeline, with byte, halfword or word size.
- Drives the memory's write-enable, read-enable, word-address and write-data pins, and returns sign- or zero-extended load data.
- Sub-word stores use read-modify-write because the memory only writes whole words.

Parameters:
- ADDR_W, 5, word-address width on the memory side; depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend loads when 1 (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned for sub-word sizes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or reserved-size request; valid with rsp_valid.
- busy  out  1  state != IDLE; the pipeline uses it as a stall.
- mem_wen  out  1  memory write enable.
- mem_readEn  out  1  memory read enable.
- mem_address  out  ADDR_W  word address, taken from req_addr[ADDR_W+1:2].
- mem_dataIn  out  32  memory write data.
- mem_dataOut  in  32  memory read data, combinational from the address.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - mem_wen = mem_readEn = rsp_valid = rsp_err = busy = 0.
  - rsp_rdata, mem_address and mem_dataIn are 0.
  - req_ready = 1.
- Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 2 occupies [31:16].
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory depth.
- IDLE:
  - req_ready = 1. Accept occurs on a clock edge with req_valid = 1.
  - On accept, latch write, size, unsigned, addr and wdata.
  - Error cases go to RESP with err = 1: size 11, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Otherwise a load or sub-word store goes to READ; a word store goes to WRITE.
  - While in IDLE, req_valid = 0 holds the state.
- READ:
  - mem_readEn = 1, mem_address = latched word address.
  - mem_dataOut is captured into the read buffer at the end of the cycle.
  - Load goes to RESP; sub-word store goes to WRITE.
- WRITE:
  - mem_wen = 1 for exactly one cycle.
  - mem_dataIn = req_wdata for a word store.
  - For a sub-word store, mem_dataIn = the read buffer with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]; other lanes are preserved.
  - Goes to RESP.
- RESP:
  - rsp_valid = 1 for one cycle, then IDLE. There is no response backpressure.
  - Load data: the selected byte or half, extended per latched req_unsigned; a word is passed through.
- Outside READ and WRITE, mem_readEn and mem_wen are 0. No memory enable is ever asserted for an error request.
- Latency, accept edge = cycle 0:
  - error: rsp_valid in cycle 1.
  - load or word store: rsp_valid in cycle 2.
  - sub-word store: rsp_valid in cycle 3.
  - The next accept is possible at the edge ending the RESP cycle.
- Inputs are ignored while busy. Request changes while busy have no effect.
- Reset mid-operation:
  - mem_wen falls immediately, so a WRITE interrupted before its edge performs no memory write.
  - No rsp_valid is produced for the aborted request.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x08, then lw 0x08. Expect mem_wen for one cycle at mem_address 2, rsp_valid at cycles 2 and 2, and rsp_rdata = 0xDEADBEEF.
- Byte merge: with word 3 = 0x11223344, sb 0xAA to addr 0x0E. Expect a READ then WRITE sequence, memory word 3 = 0x11AA3344, and rsp_valid at cycle 3.
- Sign and zero extension: with word 1 = 0x80F07F01:
  - lb 0x07 returns 0xFFFFFF80.
  - lbu 0x07 returns 0x00000080.
  - lh 0x04 returns 0x00007F01.
  - lhu 0x06 returns 0x000080F0.
- Misalignment: lw 0x05, sh 0x03 and size 11 each give rsp_valid with rsp_err = 1 one cycle after accept, rsp_rdata = 0, and no mem_wen or mem_readEn pulse.
- Back-to-back with stall: hold req_valid high for lw 0x00 then sw 0x04. Expect busy high and req_ready low for 2 cycles, the second request accepted only from IDLE, and the second request's data/address ignored while busy.
- Reset mid-store: drop rst_n during the WRITE cycle of a sw to 0x10. Expect mem_wen to fall at once, memory word 4 unchanged, no rsp_valid, and after release IDLE with req_ready = 1 and all other outputs 0.
